// File: rtl/img_capture_pipe.sv
// Image capture pipe: header emission, frame skip, thumbnail decimation,
// byte-swapped pixel output with drop-on-stall and highlight/shadow stats.
module img_capture_pipe #(
    parameter int PxWidth         = 12,
    parameter int HeaderWordCount = 8,
    parameter int SkipWidth       = 4,
    parameter int ThumbShift      = 3,
    parameter int StatWidth       = 18,
    parameter int WordCountWidth  = 24,
    parameter int HighlightThresh = (1 << PxWidth) - 32,
    parameter int ShadowThresh    = 31
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         cmd_start,
    input  logic                         cmd_abort,
    input  logic [SkipWidth-1:0]         cmd_skipCount,
    input  logic                         cmd_thumb,
    input  logic [HeaderWordCount*16-1:0] cmd_header,
    input  logic [PxWidth-1:0]           img_d,
    input  logic                         img_fv,
    input  logic                         img_lv,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_data,
    output logic                         status_busy,
    output logic                         status_done,
    output logic                         status_overflow,
    output logic [WordCountWidth-1:0]    status_wordCount,
    output logic [StatWidth-1:0]         status_highlightCount,
    output logic [StatWidth-1:0]         status_shadowCount
);

    localparam int HW  = HeaderWordCount * 16;
    localparam int HIW = $clog2(HeaderWordCount + 1);
    localparam logic [PxWidth-1:0] HiT = PxWidth'(HighlightThresh);
    localparam logic [PxWidth-1:0] ShT = PxWidth'(ShadowThresh);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_WAIT,
        S_CAPT
    } state_e;

    state_e                    state_q, state_d;
    logic [HW-1:0]             hdr_q, hdr_d;
    logic [HIW-1:0]            hidx_q, hidx_d;
    logic [SkipWidth-1:0]      skip_q, skip_d;
    logic                      thumb_q, thumb_d;
    logic                      pv_q, pv_d;
    logic [15:0]               pd_q, pd_d;
    logic                      done_q, done_d;
    logic                      ovf_q, ovf_d;
    logic [WordCountWidth-1:0] wc_q, wc_d;
    logic [StatWidth-1:0]      hi_q, hi_d;
    logic [StatWidth-1:0]      sh_q, sh_d;
    logic                      fv_q, lv_q;
    logic [ThumbShift-1:0]     x_q, y_q;

    logic        fv_rise, fv_fall, capt, hs, elig, samp, x_lt2, y_lt2;
    logic [15:0] px16;

    // Geometry counters run freely off the sensor strobes
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fv_q <= 1'b0;
            lv_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            fv_q <= img_fv;
            lv_q <= img_lv;
            x_q  <= img_lv ? x_q + 1'b1 : '0;
            if (!img_fv) y_q <= '0;
            else if (lv_q && !img_lv) y_q <= y_q + 1'b1;
        end
    end

    assign fv_rise = img_fv && !fv_q;
    assign fv_fall = !img_fv && fv_q;
    assign capt    = (state_q == S_CAPT) ||
                     (state_q == S_WAIT && fv_rise && skip_q == '0);
    assign x_lt2   = (x_q >> 1) == '0;
    assign y_lt2   = (y_q >> 1) == '0;
    assign elig    = capt && img_fv && img_lv && (!thumb_q || (x_lt2 && y_lt2));
    assign samp    = capt && img_fv && img_lv &&
                     (x_q & ThumbShift'(3)) == '0 &&
                     (y_q & ThumbShift'(3)) == '0;
    assign px16    = 16'(img_d);

    assign out_valid = (state_q == S_HEADER) || pv_q;
    assign out_data  = (state_q == S_HEADER) ? hdr_q[HW-1 -: 16] :
                       (pv_q ? pd_q : 16'h0);
    assign hs        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        hidx_d  = hidx_q;
        skip_d  = skip_q;
        thumb_d = thumb_q;
        pv_d    = elig;
        pd_d    = elig ? {px16[7:0], px16[15:8]} : pd_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        wc_d    = wc_q;
        hi_d    = hi_q;
        sh_d    = sh_q;

        if (hs && wc_q != '1) wc_d = wc_q + 1'b1;
        if (pv_q && !out_ready) ovf_d = 1'b1;
        if (samp && img_d >= HiT && hi_q != '1) hi_d = hi_q + 1'b1;
        if (samp && img_d <= ShT && sh_q != '1) sh_d = sh_q + 1'b1;

        unique case (state_q)
            S_IDLE: ;
            S_HEADER: begin
                if (hs) begin
                    hdr_d = hdr_q << 16;
                    if (hidx_q == HIW'(HeaderWordCount - 1)) state_d = S_WAIT;
                    else hidx_d = hidx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (fv_rise) begin
                    if (skip_q != '0) skip_d = skip_q - 1'b1;
                    else state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                if (fv_fall) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cmd_start) begin
            state_d = S_HEADER;
            hdr_d   = cmd_header;
            hidx_d  = '0;
            skip_d  = cmd_skipCount;
            thumb_d = cmd_thumb;
            pv_d    = 1'b0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            wc_d    = '0;
            hi_d    = '0;
            sh_d    = '0;
        end
        // Abort wins over a coincident start and never signals completion
        if (cmd_abort) begin
            state_d = S_IDLE;
            pv_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            hidx_q  <= '0;
            skip_q  <= '0;
            thumb_q <= 1'b0;
            pv_q    <= 1'b0;
            pd_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wc_q    <= '0;
            hi_q    <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            hidx_q  <= hidx_d;
            skip_q  <= skip_d;
            thumb_q <= thumb_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            wc_q    <= wc_d;
            hi_q    <= hi_d;
            sh_q    <= sh_d;
        end
    end

    assign status_busy           = state_q != S_IDLE;
    assign status_done           = done_q;
    assign status_overflow       = ovf_q;
    assign status_wordCount      = wc_q;
    assign status_highlightCount = hi_q;
    assign status_shadowCount    = sh_q;

endmodule

// File: tb/tb_img_capture_pipe.sv
// Randomized bench for img_capture_pipe against a frame-level reference
// model: expected word list, counters and flags derived per frame.
module tb_img_capture_pipe;

    localparam int HW = 128;

    logic          clk = 1'b0;
    logic          rst_;
    logic          cmd_start, cmd_abort, cmd_thumb;
    logic [3:0]    cmd_skipCount;
    logic [HW-1:0] cmd_header;
    logic [11:0]   img_d;
    logic          img_fv, img_lv;
    logic          out_valid, out_ready;
    logic [15:0]   out_data;
    logic          status_busy, status_done, status_overflow;
    logic [23:0]   status_wordCount;
    logic [17:0]   status_highlightCount, status_shadowCount;

    int total = 0;
    int bad   = 0;
    logic [15:0] got[$];
    int dones;

    img_capture_pipe dut (
        .clk                   (clk),
        .rst_                  (rst_),
        .cmd_start             (cmd_start),
        .cmd_abort             (cmd_abort),
        .cmd_skipCount         (cmd_skipCount),
        .cmd_thumb             (cmd_thumb),
        .cmd_header            (cmd_header),
        .img_d                 (img_d),
        .img_fv                (img_fv),
        .img_lv                (img_lv),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_data              (out_data),
        .status_busy           (status_busy),
        .status_done           (status_done),
        .status_overflow       (status_overflow),
        .status_wordCount      (status_wordCount),
        .status_highlightCount (status_highlightCount),
        .status_shadowCount    (status_shadowCount)
    );

    always #5 clk = ~clk;

    // Handshake outcome is fixed between edges, so sample mid-cycle
    always @(negedge clk) begin
        if (rst_) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (status_done) dones++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic lv, input logic [11:0] d,
                         input logic rdy);
        img_fv    = fv;
        img_lv    = lv;
        img_d     = d;
        out_ready = rdy;
        step();
    endtask

    function automatic logic [15:0] swap(input logic [11:0] p);
        logic [15:0] w;
        w = 16'(p);
        return {w[7:0], w[15:8]};
    endfunction

    function automatic logic [11:0] pick(input int fill, input int cval);
        int r;
        if (fill == 1) return 12'(cval);
        r = $urandom_range(2);
        if (r == 0) return 12'($urandom_range(31));
        if (r == 1) return 12'($urandom_range(4095, 4064));
        return 12'($urandom);
    endfunction

    task automatic start_hdr(input logic [HW-1:0] hdr, input int skip,
                             input logic thumb);
        cmd_start     = 1'b1;
        cmd_skipCount = 4'(skip);
        cmd_thumb     = thumb;
        cmd_header    = hdr;
        step();
        cmd_start     = 1'b0;
        cmd_skipCount = 4'($urandom);
        cmd_thumb     = 1'($urandom);
        cmd_header    = '0;
    endtask

    // drop_pct < 0 selects a fixed drop of pixel indices 3..7
    task automatic run_capture(input string nm, input int w, input int h,
                               input int skip, input logic thumb,
                               input int fill, input int cval,
                               input int drop_pct);
        logic [HW-1:0] hdr;
        logic [15:0]   exp[$];
        logic [11:0]   p;
        int hi_e, sh_e, nerr, idx, c;
        bit ovf_e, prev_drop, el, dr, cap;
        hdr = {$urandom, $urandom, $urandom, $urandom};
        got.delete();
        dones = 0;
        hi_e = 0; sh_e = 0; ovf_e = 0;
        for (int i = 0; i < 8; i++) exp.push_back(hdr[HW-1-16*i -: 16]);
        start_hdr(hdr, skip, thumb);
        c = 0;
        while (got.size() < 8 && c < 300) begin
            out_ready = ($urandom_range(99) >= 30);
            step();
            c++;
        end
        check({nm, "_hdr_len"}, 32'(got.size()), 8);
        out_ready = 1'b1;
        for (int f = 0; f <= skip; f++) begin
            cap = (f == skip);
            prev_drop = 0;
            idx = 0;
            repeat (3) drive(0, 0, 12'($urandom), 1);
            if ($urandom_range(1) == 1) drive(1, 0, 12'($urandom), 1);
            for (int y = 0; y < h; y++) begin
                for (int x = 0; x < w; x++) begin
                    p  = pick(fill, cval);
                    el = cap && (!thumb || ((x % 8) < 2 && (y % 8) < 2));
                    if (drop_pct < 0) dr = el && idx >= 3 && idx <= 7;
                    else dr = el && ($urandom_range(99) < drop_pct);
                    if (el) begin
                        idx++;
                        if (dr) ovf_e = 1;
                        else exp.push_back(swap(p));
                    end
                    if (cap && x % 4 == 0 && y % 4 == 0) begin
                        if (p >= 12'd4064) hi_e++;
                        if (p <= 12'd31) sh_e++;
                    end
                    drive(1, 1, p, !prev_drop);
                    prev_drop = dr;
                end
                drive(1, 0, 12'($urandom), !prev_drop);
                prev_drop = 0;
                if (y != h - 1) drive(1, 0, 12'($urandom), 1);
            end
        end
        repeat (4) drive(0, 0, 12'($urandom), 1);
        nerr = 0;
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            if (got[i] !== exp[i]) nerr++;
        check({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
        check({nm, "_words_bad"}, 32'(nerr), 0);
        check({nm, "_wc"}, 32'(status_wordCount), 32'(exp.size()));
        check({nm, "_ovf"}, 32'(status_overflow), 32'(ovf_e));
        check({nm, "_hi"}, 32'(status_highlightCount), 32'(hi_e));
        check({nm, "_sh"}, 32'(status_shadowCount), 32'(sh_e));
        check({nm, "_done"}, 32'(dones), 1);
        check({nm, "_busy"}, 32'(status_busy), 0);
    endtask

    initial begin
        int n0;
        rst_ = 1'b0;
        cmd_start = 0; cmd_abort = 0; cmd_thumb = 0; cmd_skipCount = 0;
        cmd_header = '0; img_d = 0; img_fv = 0; img_lv = 0; out_ready = 1;
        step(); step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(status_busy), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_wc", 32'(status_wordCount), 0);
        check("rst_ovf", 32'(status_overflow), 0);
        check("rst_done", 32'(status_done), 0);
        step();
        rst_ = 1'b1;
        step();

        run_capture("basic", 4, 4, 0, 0, 1, 12'h123, 0);
        check("basic_px0", 32'(got[8]), 32'h2301);
        check("basic_wc24", 32'(status_wordCount), 24);
        run_capture("skip", 4, 4, 2, 0, 0, 0, 0);
        check("skip_len24", 32'(got.size()), 24);
        run_capture("thumb", 16, 16, 0, 1, 0, 0, 0);
        check("thumb_len24", 32'(got.size()), 24);
        run_capture("bp", 4, 4, 0, 0, 0, 0, -1);
        check("bp_wc19", 32'(status_wordCount), 19);
        run_capture("hi", 8, 8, 0, 0, 1, 12'hFFF, 0);
        check("hi_4", 32'(status_highlightCount), 4);
        run_capture("sh", 8, 8, 0, 0, 1, 12'h000, 0);
        check("sh_4", 32'(status_shadowCount), 4);
        check("sh_hi0", 32'(status_highlightCount), 0);
        for (int k = 0; k < 6; k++)
            run_capture($sformatf("rnd%0d", k), $urandom_range(16, 1),
                        $urandom_range(16, 1), $urandom_range(2),
                        1'($urandom), 0, 0, 15);

        // Abort coinciding with start ends in Idle with no completion
        dones = 0;
        start_hdr({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        step();
        cmd_abort = 1; cmd_start = 1;
        step();
        cmd_abort = 0; cmd_start = 0;
        check("abort_busy", 32'(status_busy), 0);
        check("abort_valid", 32'(out_valid), 0);
        n0 = got.size();
        repeat (2) drive(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(1, 1, 12'h7, 1);
        repeat (3) drive(0, 0, 0, 1);
        check("abort_nowords", 32'(got.size() - n0), 0);
        check("abort_nodone", 32'(dones), 0);

        // Reset mid-capture clears outputs at once; rest of frame ignored
        start_hdr({$urandom, $urandom, $urandom, $urandom}, 0, 0);
        repeat (12) step();
        drive(1, 1, 12'hFFF, 1);
        drive(1, 1, 12'hFFF, 1);
        #1;
        rst_ = 1'b0;
        #1;
        check("rstmid_valid", 32'(out_valid), 0);
        check("rstmid_busy", 32'(status_busy), 0);
        check("rstmid_wc", 32'(status_wordCount), 0);
        check("rstmid_hi", 32'(status_highlightCount), 0);
        step();
        rst_ = 1'b1;
        dones = 0;
        n0 = got.size();
        for (int i = 0; i < 6; i++) drive(1, 1, 12'h5, 1);
        repeat (3) drive(0, 0, 0, 1);
        check("rstmid_idle", 32'(status_busy), 0);
        check("rstmid_nowords", 32'(got.size() - n0), 0);
        check("rstmid_nodone", 32'(dones), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/img_capture_pipe.md
IMG_CAPTURE_PIPE -- requirements
Module: img_capture_pipe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PxWidth, 12, pixel bits, 9..16.
- HeaderWordCount, 8, header words emitted before pixels, >=1.
- SkipWidth, 4, width of the skip-frame count.
- ThumbShift, 3, thumbnail decimation period of 2^ThumbShift, >=1.
- StatWidth, 18, width of the stat counters.
- WordCountWidth, 24, width of the word counter.
- HighlightThresh, 2^PxWidth-32, pixel >= this counts as a highlight.
- ShadowThresh, 31, pixel <= this counts as a shadow.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_, in, 1, asynchronous active-low reset.
- cmd_start, in, 1, single-cycle start pulse.
- cmd_abort, in, 1, single-cycle abort pulse.
- cmd_skipCount, in, SkipWidth, frames to skip.
- cmd_thumb, in, 1, thumbnail mode.
- cmd_header, in, HeaderWordCount*16, header; word 0 is the MS 16 bits.
- img_d, in, PxWidth, pixel data, synchronous to clk.
- img_fv, in, 1, frame valid, synchronous to clk.
- img_lv, in, 1, line valid, synchronous to clk.
- out_valid, out, 1, output word valid.
- out_ready, in, 1, sink ready.
- out_data, out, 16, output word.
- status_busy, out, 1, high when the state is not Idle.
- status_done, out, 1, single-cycle pulse on capture completion.
- status_overflow, out, 1, sticky flag: a pixel was dropped.
- status_wordCount, out, WordCountWidth, words accepted.
- status_highlightCount, out, StatWidth, highlight count.
- status_shadowCount, out, StatWidth, shadow count.

Function
REQ-003 The block SHALL implement the states Idle, Header, WaitFrame, Capture.

REQ-004 cmd_start in any state SHALL:
- latch cmd_skipCount, cmd_thumb and cmd_header;
- clear the word/stat counters and status_overflow;
- enter Header on the next cycle.

REQ-005 cmd_abort SHALL:
- force Idle on the next cycle without a status_done pulse;
- take priority when it coincides with cmd_start.

REQ-006 In Header the block SHALL present the header words in order, MS word first, and advance one word per cycle only while out_valid && out_ready.
- Header words are never dropped.
- After the last word is accepted, the block enters WaitFrame.

REQ-007 In WaitFrame, a rising edge of img_fv (prev 0, now 1) SHALL act as follows:
- if the skip count is nonzero, decrement it and stay in WaitFrame;
- if it is zero, enter Capture on that same cycle, so the first pixel of that frame is eligible.

REQ-008 The x counter SHALL reset while img_lv=0 and increment per img_lv=1 cycle; the y counter SHALL reset while img_fv=0 and increment on each img_lv falling edge. Both wrap modulo 2^ThumbShift.

REQ-009 In Capture, a pixel SHALL be eligible when img_lv=1 and either cmd_thumb=0, or both x<2 and y<2 (2x2 Bayer cell kept per 2^ThumbShift period).

REQ-010 An eligible pixel SHALL appear on out_valid/out_data exactly 1 cycle after it appears on img_d.

REQ-011 out_data SHALL be the pixel zero-extended to 16 bits, then byte-swapped (little endian).

REQ-012 A pixel word presented while out_ready=0 SHALL be dropped: it is not counted, it is not retried, and status_overflow is set to 1.

REQ-013 status_wordCount SHALL increment per accepted word, header included, and saturate at all-ones.

REQ-014 Stat sampling SHALL occur in Capture on pixels with img_lv=1, x%4==0 and y%4==0, regardless of cmd_thumb:
- highlight if px>=HighlightThresh;
- shadow if px<=ShadowThresh;
- both counters saturate at all-ones.

REQ-015 A falling edge of img_fv in Capture SHALL:
- flush any pending output word;
- pulse status_done for one cycle;
- enter Idle.

REQ-016 In Idle and WaitFrame, out_valid SHALL be 0.

REQ-017 The status counters and status_overflow SHALL hold their values in Idle until the next cmd_start.

Reset
REQ-018 While rst_=0, all state SHALL be cleared asynchronously: state=Idle, all outputs 0, all counters 0, latched commands 0.

REQ-019 Deassertion of rst_ mid-frame SHALL leave the block Idle, ignoring the remainder of the frame until cmd_start.

Verification
REQ-020 Basic frame: HeaderWordCount=8, skip=0, thumb=0, 4x4 frame of px=0x123, out_ready=1 -> 8 header words, then 16 words of 0x2301, then status_done; status_wordCount=24.

REQ-021 Skip frames: skip=2, three frames sent -> only the third frame is captured; status_done pulses once.

REQ-022 Thumbnail: thumb=1, ThumbShift=3, 16x16 frame -> 16 pixel words (x,y in {0,1,8,9}).

REQ-023 Backpressure: out_ready=0 during header word 3 -> header stalls with no loss; out_ready=0 for 5 pixel cycles -> 5 words dropped, status_overflow=1, wordCount reduced by 5.

REQ-024 Stats: 8x8 frame, all px=0xFFF -> highlightCount=4, shadowCount=0; repeat with px=0 -> shadowCount=4 and highlightCount=0 after the restart clears the counters.

REQ-025 Control: cmd_abort with cmd_start in the same cycle -> Idle with no status_done; rst_ pulse mid-Capture -> all outputs 0 immediately.
